div_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the CPU's 32-bit division datapath: accepts a dividend/divisor pair on a start/done handshake and iterates one restoring-division step per clock. Replaces the single-cycle combinational divide path in the ALU stage, which is too slow for the target clock. Results feed the HI (remainder) and LO (quotient) register load path. The control unit stalls on `busy`.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 30 +++
 rtl/div_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizes for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: div_state_t sequencer states, DIV_W operand width,
// DIV_CNT_W iteration counter width.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into R, trial-subtract M.
// Latency: combinational.
// Backpressure: none.
//
// Ports: r_i/q_i/m_i partial remainder, quotient/dividend shift register, divisor;
//        r_o/q_o updated partial remainder and shift register.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    // The shifted remainder keeps R's MSB as an extra bit: for divisors with the
    // top bit set, R can be >= 2^(WIDTH-1) and dropping that bit would corrupt
    // the trial subtraction. The difference always fits WIDTH+1 bits signed.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {r_i, q_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, m_i};

    // diff[WIDTH] set means the trial subtraction went negative: restore.
    assign r_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer: quotient -> LO, remainder -> HI.
// Latency: done 34 cycles after the accepting edge (2 cycles for divide by zero).
// Backpressure: start is only accepted in IDLE/DONE; the caller stalls on busy.
//
// Ports: clock, reset_n (async active-low); start, is_signed, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out (registered).
// Build option: define DIV_SIGNED_EN to honour is_signed; otherwise all divides are unsigned.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] r_q;      // partial remainder
    logic [WIDTH-1:0] q_q;      // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] m_q;      // divisor magnitude
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;

    logic             m_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_src;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    assign m_zero = (m_q == '0);

    // On divide by zero the iteration is skipped, so q_q still holds the
    // dividend magnitude; re-applying the dividend sign restores the original.
    assign rem_src = m_zero ? q_q : r_q;

`ifdef DIV_SIGNED_EN
    logic sgn_a_q;
    logic sgn_b_q;
    logic a_neg;
    logic b_neg;

    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];
    // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor  : divisor;
    assign fix_quo = (sgn_a_q ^ sgn_b_q) ? -q_q : q_q;
    assign fix_rem = sgn_a_q ? -rem_src : rem_src;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign fix_quo = q_q;
    assign fix_rem = rem_src;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .m_i (m_q),
        .r_o (r_d),
        .q_o (q_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_SIGNED_EN
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        q_q     <= a_mag;
                        m_q     <= b_mag;
                        r_q     <= '0;
                        cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
                        sgn_a_q <= a_neg;
                        sgn_b_q <= b_neg;
`endif
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    busy_q  <= 1'b1;
                    state_q <= m_zero ? FIX : ITER;
                end
                ITER: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quo_q   <= m_zero ? '1 : fix_quo;
                    rem_q   <= fix_rem;
                    dbz_q   <= m_zero;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_seq_ctrl;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_errors;
    int cyc;
    int last_done_cyc;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Division by the language's own arithmetic; signed divide truncates toward zero
    // and the remainder follows the dividend, which is the behaviour required here.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else if (sgn && SIGNED_BUILD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one operation; poke_at injects a spurious start, rst_at aborts with reset.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int poke_at, input int rst_at);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int exp_lat;
        int lat;
        int busy_cnt;
        bit seen_done;
        bit overlap;
        bit late_done;
        ref_div(a, b, sgn, eq, er, ez);
        exp_lat = ez ? 2 : 34;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        @(posedge clock);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        chk("busy_done_after_accept", {busy, done}, 64'd0);
        lat = 0;
        busy_cnt = 0;
        seen_done = 1'b0;
        overlap = 1'b0;
        for (int k = 1; k <= 60 && !seen_done; k++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                seen_done = 1'b1;
                lat = k;
                last_done_cyc = cyc;
            end
            if (k == 5) chk("outputs_hold", {quotient, remainder}, {prev_q, prev_r});
            if (k == poke_at) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom_range(1, 50);
                is_signed = 1'($urandom);
            end
            if (k == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_ctrl", {busy, done, div_by_zero}, 64'd0);
                chk("rst_quotient", quotient, 64'd0);
                chk("rst_remainder", remainder, 64'd0);
                late_done = 1'b0;
                repeat (3) begin
                    @(posedge clock);
                    #1;
                    if (done || busy) late_done = 1'b1;
                end
                chk("rst_no_done", late_done, 64'd0);
                reset_n = 1'b1;
                prev_q = '0;
                prev_r = '0;
                return;
            end
        end
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat - 1);
        chk("busy_done_overlap", overlap, 64'd0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int t0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        last_done_cyc = 0;
        prev_q = '0;
        prev_r = '0;
        reset_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ctrl", {busy, done, div_by_zero}, 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_op(32'd100, 32'd7, 1'b0, -1, -1);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1);
        do_op(32'd5, 32'd0, 1'b0, -1, -1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
        do_op(32'hFFFF_FFFE, 32'h8000_0001, 1'b0, -1, -1);

        // spurious start during ITER step 10
        do_op(32'd1000, 32'd3, 1'b0, 11, -1);

        // start in the DONE cycle: next done 35 cycles after the previous one
        do_op(32'd12345, 32'd67, 1'b0, -1, -1);
        t0 = last_done_cyc;
        do_op(32'd999, 32'd10, 1'b0, -1, -1);
        chk("back_to_back_gap", last_done_cyc - t0, 64'd35);

        // reset during ITER step 10, then a fresh operation
        do_op(32'd77777, 32'd13, 1'b0, -1, 11);
        do_op(32'hFFFF_FFFF, 32'h10, 1'b0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 20));
                3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
